calc_g_scan_ctrl: RTL

Sweep controller that drives the `(m, n, zparam)` inputs of the G-kernel pipeline (`calc_G_top`) and collects its `G_re`/`G_im` outputs. On `start` it issues every grid point `(m, n)` of a square window, one per cycle, and tags each issue with its coordinates. It re-aligns returning results to their tags after the fixed pipeline latency and delivers them to a downstream consumer through a valid/ready interface. The kernel pipeline cannot stall, so a credit scheme guarantees that no result is ever lost under backpressure.

---
 rtl/calc_g_scan_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/calc_g_scan_ctrl.sv
// Sweep controller for the G-kernel pipeline: scans an (m, n) window, re-tags the
// fixed-latency kernel results and buffers them behind a credit-guarded result FIFO.
module calc_g_scan_ctrl #(
  parameter int HALF       = 8,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        zparam_in,
  output logic               busy,
  output logic               done,
  output logic signed [9:0]  m_out,
  output logic signed [9:0]  n_out,
  output logic [31:0]        zparam_out,
  output logic               issue,
  input  logic signed [15:0] G_re_in,
  input  logic signed [15:0] G_im_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [9:0]  res_m,
  output logic signed [9:0]  res_n,
  output logic signed [15:0] res_re,
  output logic signed [15:0] res_im
);

  localparam int unsigned CW    = 10;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OST_W = $clog2(FIFO_DEPTH + LATENCY + 2);
  localparam logic signed [CW-1:0] C_MIN = CW'(-HALF);
  localparam logic signed [CW-1:0] C_MAX = CW'(HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic signed [CW-1:0] m;
    logic signed [CW-1:0] n;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } res_t;

  state_t               state, state_nxt;
  logic                 issue_nxt, busy_nxt, done_nxt;
  logic signed [CW-1:0] m_nxt, n_nxt;
  logic [31:0]          z_nxt;

  logic [LATENCY-1:0]   tag_v;
  logic signed [CW-1:0] tag_m [LATENCY];
  logic signed [CW-1:0] tag_n [LATENCY];
  logic [OST_W-1:0]     inflight, outstanding;
  logic                 credit_ok;

  res_t                 mem [FIFO_DEPTH];
  res_t                 head, head_nxt, push_data;
  logic [AW-1:0]        wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0]     count, count_nxt;
  logic                 push, pop;

  // Every issued-but-unpopped point owns a FIFO slot, so a push can never find the FIFO full
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + OST_W'(tag_v[i]);
    outstanding = OST_W'(count) + inflight + OST_W'(issue);
    credit_ok   = outstanding < OST_W'(FIFO_DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue_nxt = 1'b0;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    m_nxt     = m_out;
    n_nxt     = n_out;
    z_nxt     = zparam_out;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          z_nxt     = zparam_in;
          m_nxt     = C_MIN;
          n_nxt     = C_MIN;
          issue_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (issue && m_out == C_MAX && n_out == C_MAX) begin
          state_nxt = S_DRAIN;
        end else begin
          // Advance only past a point that was actually issued; a stalled point is held
          if (issue) begin
            if (m_out == C_MAX) begin
              m_nxt = C_MIN;
              n_nxt = n_out + 10'sd1;
            end else begin
              m_nxt = m_out + 10'sd1;
            end
          end
          issue_nxt = credit_ok;
        end
      end
      S_DRAIN: begin
        if (inflight == '0 && count == '0) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      m_out      <= '0;
      n_out      <= '0;
      zparam_out <= '0;
    end else begin
      issue      <= issue_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      m_out      <= m_nxt;
      n_out      <= n_nxt;
      zparam_out <= z_nxt;
    end
  end

  // Tag pipe mirrors the kernel latency so results re-join their coordinates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= issue;
      for (int i = 1; i < LATENCY; i++) tag_v[i] <= tag_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_m[0] <= m_out;
    tag_n[0] <= n_out;
    for (int i = 1; i < LATENCY; i++) begin
      tag_m[i] <= tag_m[i-1];
      tag_n[i] <= tag_n[i-1];
    end
  end

  assign push      = tag_v[LATENCY-1];
  assign pop       = res_valid & res_ready;
  assign push_data = '{m: tag_m[LATENCY-1], n: tag_n[LATENCY-1], re: G_re_in, im: G_im_in};

  // Head register is preloaded with the next entry, bypassing a same-edge push into an empty FIFO
  always_comb begin
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    rd_nxt    = rd_ptr + AW'(pop);
    if (push && wr_ptr == rd_nxt) head_nxt = push_data;
    else                          head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      head      <= '0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      res_valid <= count_nxt != '0;
      if (count_nxt != '0) head <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_no_overflow: assert (!(push && !pop && count == CNT_W'(FIFO_DEPTH)));
    end
  end

  assign res_m  = head.m;
  assign res_n  = head.n;
  assign res_re = head.re;
  assign res_im = head.im;

endmodule
